// File: rtl/cache_def.sv
// Shared type definitions for the accumulating cache and its request feeders.
// Holds the cache request/response buses and the cancelled-order event record.
// Also holds the address-mapping and saturating-add helpers used by the feeder.
package cache_def;

    // The cache index is 14 bits wide: line index [13:4], word select [3:2], byte [1:0].
    localparam int CACHE_INDEX_W = 14;
    // The client ID occupies the line-index field [13:4].
    localparam int CLIENT_W      = 10;

    typedef struct packed {
        logic                     valid;
        logic                     rw;       // 1 = write (accumulate)
        logic [CACHE_INDEX_W-1:0] rdindex;
        logic [CACHE_INDEX_W-1:0] wrindex;
        logic [31:0]              data;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [CLIENT_W-1:0] client;
        logic [31:0]         qty;
    } cancel_evt_type;

    // A client maps onto one cache line; the word select and byte bits stay zero.
    function automatic logic [CACHE_INDEX_W-1:0] client_to_index(input logic [CLIENT_W-1:0] client);
        return CACHE_INDEX_W'({client, 4'b0000});
    endfunction

    // Quantity accumulation clamps at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/cancel_evt_fifo.sv
// Purpose: small circular FIFO of cancel events with tail read/update for coalescing.
// Latency: a push is visible at the head/tail outputs in the cycle after the write edge.
// Backpressure: full is derived from the occupancy register only; a pop never frees a slot in the same cycle.
//
// Ports: clk, rst (sync, active-high); push/push_evt write the tail; pop retires the head;
// tail_upd/tail_qty overwrite the tail entry's qty; head_lock marks the head as in flight.
// Outputs: full, empty, head_evt, tail_evt, tail_locked (tail entry is the locked head).
module cancel_evt_fifo
    import cache_def::*;
#(
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  cancel_evt_type push_evt,
    input  logic           pop,
    input  logic           tail_upd,
    input  logic [31:0]    tail_qty,
    input  logic           head_lock,
    output logic           full,
    output logic           empty,
    output cancel_evt_type head_evt,
    output cancel_evt_type tail_evt,
    output logic           tail_locked
);

    localparam int AW = $clog2(DEPTH);

    cancel_evt_type mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  tail_ptr;
    logic [AW:0]    count;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign tail_ptr = wr_ptr - AW'(1);
    assign head_evt = mem[rd_ptr];
    assign tail_evt = mem[tail_ptr];

    // With a single entry the tail is the head; if that head is in flight its
    // qty has already been copied into the request and must not change.
    assign tail_locked = head_lock && (count == (AW+1)'(1));

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_evt;
        end else if (tail_upd) begin
            mem[tail_ptr].qty <= tail_qty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cancel_order_feeder.sv
// Purpose: turns buffered cancelled-order events into accumulate-write requests for the cache.
// Latency: event accepted at edge N into an idle, empty block -> cpu_req.valid high after edge N+1.
// Backpressure: in_ready = !full; each request is held until cpu_res.ready or TIMEOUT cycles, then one idle gap.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_client/in_qty event input;
// cpu_req/cpu_res cache request bus; busy; sent_count (wraps); timeout_count (saturates);
// timeout_err (one-cycle pulse per dropped request).
// Optional feature: CANCEL_COALESCE_EN merges an event into the FIFO tail when the client matches.
// ID_W must not exceed cache_def::CLIENT_W.
module cancel_order_feeder
    import cache_def::*;
#(
    parameter int DEPTH   = 8,
    parameter int ID_W    = 10,
    parameter int TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_client,
    input  logic [31:0]     in_qty,
    output cpu_req_type     cpu_req,
    input  cpu_result_type  cpu_res,
    output logic            busy,
    output logic [15:0]     sent_count,
    output logic [7:0]      timeout_count,
    output logic            timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t          state;
    cpu_req_type     req_q;
    logic [CNT_W-1:0] wait_cnt;

    logic            accept;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            tail_upd;
    logic [31:0]     tail_qty;
    logic            head_lock;
    logic            tail_locked;
    logic            wait_hit;
    cancel_evt_type  in_evt;
    cancel_evt_type  head_evt;
    cancel_evt_type  tail_evt;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign in_evt.client = CLIENT_W'(in_client);
    assign in_evt.qty    = in_qty;

    // The head is in flight from the edge that copies it (IDLE with data)
    // until the edge that pops it (end of REQ).
    assign head_lock = (state == S_REQ) || ((state == S_IDLE) && !fifo_empty);

    assign wait_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign fifo_pop = (state == S_REQ) && (cpu_res.ready || wait_hit);

`ifdef CANCEL_COALESCE_EN
    logic coalesce;
    assign coalesce  = accept && !fifo_empty && !tail_locked
                       && (tail_evt.client == in_evt.client);
    assign fifo_push = accept && !coalesce;
    assign tail_upd  = coalesce;
    assign tail_qty  = sat_add32(tail_evt.qty, in_qty);
`else
    logic unused_tail;
    assign fifo_push   = accept;
    assign tail_upd    = 1'b0;
    assign tail_qty    = '0;
    assign unused_tail = ^{tail_evt, tail_locked};
`endif

    // The cache response data is not needed for accumulate writes.
    logic unused_res;
    assign unused_res = ^cpu_res.data;

    cancel_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_evt    (in_evt),
        .pop         (fifo_pop),
        .tail_upd    (tail_upd),
        .tail_qty    (tail_qty),
        .head_lock   (head_lock),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_evt    (head_evt),
        .tail_evt    (tail_evt),
        .tail_locked (tail_locked)
    );

    assign cpu_req = req_q;
    assign busy    = !fifo_empty || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            req_q         <= '0;
            wait_cnt      <= '0;
            sent_count    <= '0;
            timeout_count <= '0;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        req_q.valid   <= 1'b1;
                        req_q.rw      <= 1'b1;
                        req_q.rdindex <= client_to_index(head_evt.client);
                        req_q.wrindex <= client_to_index(head_evt.client);
                        req_q.data    <= head_evt.qty;
                        wait_cnt      <= '0;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (cpu_res.ready) begin
                        req_q.valid <= 1'b0;
                        sent_count  <= sent_count + 16'd1;
                        state       <= S_GAP;
                    end else if (wait_hit) begin
                        req_q.valid <= 1'b0;
                        timeout_err <= 1'b1;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                        state <= S_GAP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                // One cycle with valid low so the cache returns to idle before
                // the next accumulate.
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cancel_order_feeder.sv
// Directed bench for cancel_order_feeder: reset, single event, full FIFO drain,
// timeout drop, reset mid-request and same-client bursts (coalesced or not).
module tb_cancel_order_feeder;
    import cache_def::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [9:0]     in_client;
    logic [31:0]    in_qty;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    logic           busy;
    logic [15:0]    sent_count;
    logic [7:0]     timeout_count;
    logic           timeout_err;

    logic auto_ready;
    logic force_ready;

    int checks = 0;
    int errors = 0;

    logic [CACHE_INDEX_W-1:0] log_wr[$];
    logic [CACHE_INDEX_W-1:0] log_rd[$];
    logic [31:0]              log_dat[$];

    always #5 clk = ~clk;

    // Cache stand-in: answers ready in the same cycle valid is seen, when enabled.
    always_comb begin
        cpu_res.data  = 32'h0;
        cpu_res.ready = force_ready | (auto_ready & cpu_req.valid);
    end

    // Record every request the cache accepts.
    always @(posedge clk) begin
        if (!rst && cpu_req.valid && cpu_res.ready) begin
            log_wr.push_back(cpu_req.wrindex);
            log_rd.push_back(cpu_req.rdindex);
            log_dat.push_back(cpu_req.data);
        end
    end

    cancel_order_feeder #(
        .DEPTH   (8),
        .ID_W    (10),
        .TIMEOUT (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_client     (in_client),
        .in_qty        (in_qty),
        .cpu_req       (cpu_req),
        .cpu_res       (cpu_res),
        .busy          (busy),
        .sent_count    (sent_count),
        .timeout_count (timeout_count),
        .timeout_err   (timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] client, input logic [31:0] qty);
        in_valid  = 1'b1;
        in_client = client;
        in_qty    = qty;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                       base;
        bit                       seen;
        logic [CACHE_INDEX_W-1:0] exp_wr[$];
        logic [31:0]              exp_dat[$];

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_client   = '0;
        in_qty      = '0;
        auto_ready  = 1'b0;
        force_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sent", 64'(sent_count), 64'd0);
        check("rst_tcount", 64'(timeout_count), 64'd0);
        check("rst_terr", 64'(timeout_err), 64'd0);
        check("rst_cpu_req", 64'(cpu_req), 64'd0);

        // Single event: client 5, qty 100
        auto_ready = 1'b1;
        send(10'd5, 32'd100);
        check("single_busy_after_accept", 64'(busy), 64'd1);
        check("single_valid_not_yet", 64'(cpu_req.valid), 64'd0);
        tick();
        check("single_valid", 64'(cpu_req.valid), 64'd1);
        check("single_rw", 64'(cpu_req.rw), 64'd1);
        check("single_wrindex", 64'(cpu_req.wrindex), 64'h50);
        check("single_rdindex", 64'(cpu_req.rdindex), 64'h50);
        check("single_data", 64'(cpu_req.data), 64'd100);
        tick();
        check("single_gap_valid", 64'(cpu_req.valid), 64'd0);
        check("single_sent", 64'(sent_count), 64'd1);
        tick();
        check("single_idle_valid", 64'(cpu_req.valid), 64'd0);
        check("single_idle_busy", 64'(busy), 64'd0);
        check("single_log_n", 64'(log_wr.size()), 64'd1);
        auto_ready = 1'b0;

        // Ready outside REQ is ignored
        force_ready = 1'b1;
        repeat (3) tick();
        force_ready = 1'b0;
        check("ready_idle_ignored", 64'(sent_count), 64'd1);

        // Eight back-to-back events, ready held low
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_client = 10'(16 + i);
            in_qty    = 32'(1000 + i);
            if (i == 7) check("fill_ready_before_8th", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        check("fill_ready_low_after_8th", 64'(in_ready), 64'd0);
        auto_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (sent_count != 16'd9 && n < 100) begin
                tick();
                n++;
            end
        end
        check("fill_sent", 64'(sent_count), 64'd9);
        wait_idle("fill_drain_idle", 50);
        check("fill_in_ready", 64'(in_ready), 64'd1);
        check("fill_log_n", 64'(log_wr.size()), 64'd9);
        for (int i = 0; i < 8; i++) begin
            if (i < log_wr.size() - 1) begin
                check($sformatf("fill_wr_%0d", i), 64'(log_wr[i+1]), 64'((16 + i) * 16));
                check($sformatf("fill_dat_%0d", i), 64'(log_dat[i+1]), 64'(1000 + i));
            end
        end
        check("fill_tcount", 64'(timeout_count), 64'd0);
        auto_ready = 1'b0;

        // Timeout: head dropped after 32 REQ cycles, next event issued
        base = log_wr.size();
        send(10'h3FF, 32'd7);
        send(10'd2, 32'd9);
        check("to_valid_first", 64'(cpu_req.valid), 64'd1);
        check("to_wrindex_first", 64'(cpu_req.wrindex), 64'h3FF0);
        seen = 1'b0;
        for (int i = 0; i < 31; i++) begin
            tick();
            seen |= timeout_err;
        end
        check("to_no_early_pulse", 64'(seen), 64'd0);
        check("to_valid_cycle32", 64'(cpu_req.valid), 64'd1);
        tick();
        check("to_pulse", 64'(timeout_err), 64'd1);
        check("to_count", 64'(timeout_count), 64'd1);
        check("to_valid_gap", 64'(cpu_req.valid), 64'd0);
        tick();
        check("to_pulse_one_cycle", 64'(timeout_err), 64'd0);
        check("to_valid_idle", 64'(cpu_req.valid), 64'd0);
        tick();
        check("to_next_valid", 64'(cpu_req.valid), 64'd1);
        check("to_next_wrindex", 64'(cpu_req.wrindex), 64'h20);
        check("to_next_data", 64'(cpu_req.data), 64'd9);
        auto_ready = 1'b1;
        tick();
        check("to_sent", 64'(sent_count), 64'd10);
        check("to_log_n", 64'(log_wr.size()), 64'(base + 1));
        auto_ready = 1'b0;
        tick();

        // Reset during REQ
        send(10'd9, 32'd5);
        send(10'd11, 32'd6);
        check("rstmid_valid_before", 64'(cpu_req.valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_cpu_req", 64'(cpu_req), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        check("rstmid_sent", 64'(sent_count), 64'd0);
        check("rstmid_tcount", 64'(timeout_count), 64'd0);
        check("rstmid_terr", 64'(timeout_err), 64'd0);
        repeat (40) tick();
        check("rstmid_no_timeout", 64'(timeout_count), 64'd0);
        check("rstmid_still_idle", 64'(busy), 64'd0);

        // Same-client bursts behind an in-flight client 3
        base = log_wr.size();
        send(10'd3, 32'd1);
        send(10'd7, 32'd10);
        send(10'd7, 32'd20);
        send(10'd7, 32'd30);
        send(10'd8, 32'hFFFF_FFF0);
        send(10'd8, 32'h20);
        exp_wr.push_back(14'h30);  exp_dat.push_back(32'd1);
`ifdef CANCEL_COALESCE_EN
        exp_wr.push_back(14'h70);  exp_dat.push_back(32'd60);
        exp_wr.push_back(14'h80);  exp_dat.push_back(32'hFFFF_FFFF);
`else
        exp_wr.push_back(14'h70);  exp_dat.push_back(32'd10);
        exp_wr.push_back(14'h70);  exp_dat.push_back(32'd20);
        exp_wr.push_back(14'h70);  exp_dat.push_back(32'd30);
        exp_wr.push_back(14'h80);  exp_dat.push_back(32'hFFFF_FFF0);
        exp_wr.push_back(14'h80);  exp_dat.push_back(32'h20);
`endif
        auto_ready = 1'b1;
        wait_idle("burst_drain_idle", 200);
        check("burst_log_n", 64'(log_wr.size() - base), 64'(exp_wr.size()));
        check("burst_sent", 64'(sent_count), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (base + i < log_wr.size()) begin
                check($sformatf("burst_wr_%0d", i), 64'(log_wr[base+i]), 64'(exp_wr[i]));
                check($sformatf("burst_rd_%0d", i), 64'(log_rd[base+i]), 64'(exp_wr[i]));
                check($sformatf("burst_dat_%0d", i), 64'(log_dat[base+i]), 64'(exp_dat[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
